// File: rtl/ebr_sh_ctrl_if.sv
// ebr_sh_ctrl_if: control/status bundle between ebr_sh_ctrl and the EBR delay-line bank
// EBR_SH_CTRL_STALL_EN adds the hold input
interface ebr_sh_ctrl_if #(parameter int SLOT_W = 5);
    logic              clr_req;
    logic              cen;
    logic              sh_rst;
    logic [SLOT_W-1:0] slot;
    logic              sync;
    logic              busy;
    logic              clr_ack;
`ifdef EBR_SH_CTRL_STALL_EN
    logic              hold;
    modport master (output clr_req, hold, input cen, sh_rst, slot, sync, busy, clr_ack);
    modport slave  (input clr_req, hold, output cen, sh_rst, slot, sync, busy, clr_ack);
`else
    modport master (output clr_req, input cen, sh_rst, slot, sync, busy, clr_ack);
    modport slave  (input clr_req, output cen, sh_rst, slot, sync, busy, clr_ack);
`endif
endinterface

// File: rtl/ebr_sh_ctrl.sv
// ebr_sh_ctrl: clock-enable, slot counter and delay-line wipe controller for the EBR delay bank
// EBR_SH_CTRL_STALL_EN adds hold, which freezes the divider and suppresses cen
module ebr_sh_ctrl #(
    parameter int DIV      = 2,
    parameter int STAGES   = 32,
    parameter int SLOT_W   = 5,
    parameter int WIPE_LEN = 64
) (
    input logic          clk,
    input logic          rst,
    ebr_sh_ctrl_if.slave bus
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int WW = WIPE_LEN > 1 ? $clog2(WIPE_LEN) : 1;
    typedef enum logic [1:0] {WIPE_INIT, RUN, WIPE_REQ, ACK} state_t;
    state_t            state, state_nx;
    logic [DW-1:0]     div_cnt;
    logic [WW-1:0]     wipe_cnt, wipe_nx;
    logic [SLOT_W-1:0] slot;
    logic              cen, sh_rst, clr_ack, hold;
    logic              div_last, frame_end, wipe_last, wiping;
`ifdef EBR_SH_CTRL_STALL_EN
    assign hold = bus.hold;
`else
    assign hold = 1'b0;
`endif
    assign div_last  = div_cnt == DW'(DIV - 1);
    assign frame_end = slot == SLOT_W'(STAGES - 1);
    assign wipe_last = wipe_cnt == WW'(WIPE_LEN - 1);
    assign wiping    = state == WIPE_INIT || state == WIPE_REQ;
    always_comb begin
        state_nx = state;
        case (state)
            WIPE_INIT, WIPE_REQ: if (cen && wipe_last) state_nx = state == WIPE_INIT ? RUN : ACK;
            RUN:                 if (cen && frame_end && bus.clr_req) state_nx = WIPE_REQ;
            default:             state_nx = RUN;
        endcase
        wipe_nx = (wiping && cen) ? (wipe_last ? '0 : wipe_cnt + 1'b1) : wipe_cnt;
    end
    // Outputs are registered from the next state so the wipe edge lines up with the slot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WIPE_INIT;
            div_cnt  <= '0;
            wipe_cnt <= '0;
            slot     <= '0;
            cen      <= 1'b0;
            sh_rst   <= 1'b1;
            clr_ack  <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= hold ? div_cnt : (div_last ? '0 : div_cnt + 1'b1);
            wipe_cnt <= wipe_nx;
            slot     <= cen ? (frame_end ? '0 : slot + 1'b1) : slot;
            cen      <= !hold && div_last;
            sh_rst   <= state_nx == WIPE_INIT || state_nx == WIPE_REQ;
            clr_ack  <= state_nx == ACK;
        end
    end
    assign bus.cen     = cen;
    assign bus.sh_rst  = sh_rst;
    assign bus.slot    = slot;
    assign bus.sync    = slot == '0;
    assign bus.busy    = sh_rst;
    assign bus.clr_ack = clr_ack;
endmodule

// File: doc/ebr_sh_ctrl.md
Name: ebr_sh_ctrl

Overview:
- Timing and housekeeping controller for the bank of EBR delay lines (32-slot operator pipeline).
- Generates the shared clock-enable and the slot counter with frame sync.
- Owns the delay-line wipe: drives the delay lines' reset/wipe input for a full RAM sweep after power-up reset and on software clear requests, with a req/ack handshake.

Parameters:
- DIV, 2: clk cycles per cen pulse (>=1; DIV=1 gives cen constantly high after reset).
- STAGES, 32: slots per frame; slot wraps STAGES-1 -> 0.
- SLOT_W, 5: slot output width; must hold STAGES-1.
- WIPE_LEN, 64: cen pulses sh_rst is held per wipe; equals RAM depth 2**clog2(STAGES+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clr_req  in  1  level request for a full delay-line clear; hold until clr_ack.
- cen  out  1  registered clock-enable to all delay lines, one clk wide every DIV clks.
- sh_rst  out  1  registered wipe/reset to delay lines; high = wipe mode.
- slot  out  SLOT_W  current slot index.
- sync  out  1  high while slot==0.
- busy  out  1  high while a wipe is in progress (sh_rst copy, for muting output).
- clr_ack  out  1  one-clk pulse when a requested clear completes.

Behaviour:
- Reset values: cen=0, sh_rst=1, slot=0, sync=1, busy=1, clr_ack=0, div_cnt=0, wipe_cnt=0, state=WIPE_INIT.
- Divider:
  - div_cnt counts 0..DIV-1 each clk and wraps.
  - cen is registered high in the clk where div_cnt==DIV-1, so the first cen is the DIV-th cycle after rst release.
- Slot:
  - Increments on each clk edge where cen=1; STAGES-1 -> 0.
  - Never stops, including during wipes.
  - sync is combinational from slot.
- States:
  - WIPE_INIT: entered on rst.
  - RUN: normal operation.
  - WIPE_REQ: software clear in progress.
  - ACK: one clk; not a wait state.
- WIPE_INIT / WIPE_REQ:
  - sh_rst=1, busy=1.
  - wipe_cnt increments on each cen.
  - On a cen with wipe_cnt==WIPE_LEN-1: clear wipe_cnt. WIPE_INIT -> RUN; WIPE_REQ -> ACK.
  - sh_rst is therefore high for exactly WIPE_LEN cen pulses.
- RUN:
  - sh_rst=0.
  - If clr_req=1 on the cen edge where slot==STAGES-1 (frame end), go to WIPE_REQ. The wipe starts aligned to slot 0.
- ACK: clr_ack=1 for one clk, sh_rst=0, then RUN.
- Boundaries:
  - clr_req during WIPE_INIT is not accepted until RUN, then waits for the next frame end.
  - clr_req dropped before acceptance cancels the request silently.
  - clr_req still high in the clk after clr_ack counts as a new request.
  - clr_req rising exactly on the frame-end cen edge is accepted.
  - rst asserted mid-wipe or mid-frame returns immediately to reset values; the wipe restarts from 0.
  - DIV=1: cen held 1 from the first clk after rst release; all counting is per clk.

Optional Feature:
- Macro EBR_SH_CTRL_STALL_EN.
- Defined:
  - Adds input port hold (1 bit).
  - While hold=1, div_cnt is frozen and cen is forced to 0 (registered, so cen drops the clk after hold rises). Slot and wipe_cnt therefore also freeze.
  - On hold release, the divider resumes from its frozen count.
  - Reset behaviour unchanged.
- Not defined: port absent; the divider always runs.

Test Plan:
- Power-up: rst 3 clks then release, DIV=2 -> cen in clks 2,4,6...; sh_rst=1 for exactly 64 cen pulses (128 clks), then 0; slot==0 and sync=1 at the 32nd and 64th cen; busy tracks sh_rst.
- Software clear: in RUN, raise clr_req at slot 10 -> sh_rst rises on the edge where slot 31 -> 0, stays high for 64 cen; clr_ack pulses one clk after; drop clr_req -> no further wipe over 3 frames.
- Request during init wipe: clr_req=1 from the clk after rst release -> first wipe 64 cen, then RUN for exactly one frame (32 cen), then second wipe of 64 cen, then clr_ack.
- Cancelled request: clr_req high at slots 5..20 only -> sh_rst never rises, clr_ack never pulses.
- Reset mid-wipe: assert rst at wipe_cnt=30 -> all outputs at reset values immediately; after release a full 64-cen wipe occurs; DIV=1 build shows cen=1 every clk after release.
- EBR_SH_CTRL_STALL_EN: hold=1 for 10 clks in RUN at slot 7 -> no cen, slot stays 7; after release cen spacing resumes at DIV from the frozen phase.
